// File: rtl/uart_rx_byte_pkg.sv
// Shared constants for the UART receive path.
//   - UART_DATA_BITS     : data bits per 8N1 frame
//   - UART_CLKS_PER_BIT  : default baud divider (50 MHz / 115200); the RX
//                          block and a future TX block share this constant
//   - state_t / ST_*     : 3-bit receiver state encodings
package uart_rx_byte_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_STOP      = 3'd3;
  localparam state_t ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   i_d   : asynchronous input
//   o_q   : synchronized output (2 cycles of latency)
module uart_rx_byte_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver feeding the program-load path.
// Each correctly framed byte appears on o_data_out with a one-cycle
// o_data_valid strobe; a low stop bit gives a one-cycle o_frame_err pulse
// and leaves o_data_out untouched.
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   i_rx         : asynchronous serial line, idles high
//   o_data_out   : last correctly received byte (held until the next one)
//   o_data_valid : one-cycle pulse, o_data_out is new
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_busy       : high whenever the receiver is not in IDLE
//
// Handshake: o_data_valid is a pure strobe with no ready/back-pressure;
// the consumer must take o_data_out on (or any time after) the cycle the
// strobe is high, before the next strobe.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_data_out,
  output logic                      o_data_valid,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  // Last counter value before a sample point: half a bit for the start
  // bit (lands mid-bit), a full bit for data and stop bits.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_busy;

  state_t                    w_state_next;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [2:0]                w_idx_next;
  logic [UART_DATA_BITS-1:0] w_shift_next;

  logic                      w_stop_point;
  logic                      w_valid_next;
  logic                      w_ferr_next;
  logic [UART_DATA_BITS-1:0] w_data_next;
  logic                      w_busy_next;

  uart_rx_byte_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  // State register plus the datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic. The counter returns to 0 at every sample point so it
  // never runs past BIT_LAST.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (!w_rx_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          // Line back high at mid start bit means it was a glitch.
          w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = '0;
          // LSB arrives first; shifting right leaves it in bit 0 at the end.
          w_shift_next = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
          if (r_idx == IDX_LAST) begin
            w_state_next = ST_STOP;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = '0;
          // Returning to IDLE at mid stop bit leaves half a bit to catch a
          // back-to-back start edge.
          w_state_next = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        // Absorbs a break so it reports one frame error and no bytes.
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic: values registered into the output flops above.
  always_comb begin
    w_stop_point = (r_state == ST_STOP) && (r_cnt == BIT_LAST);
    w_valid_next = w_stop_point && w_rx_s;
    w_ferr_next  = w_stop_point && !w_rx_s;
    w_data_next  = w_valid_next ? r_shift : r_data;
    w_busy_next  = (w_state_next != ST_IDLE);
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

  localparam int CPB = 16;
  // Start edge (rx set just after posedge P) to visible data_valid:
  // 9.5 bit-times to mid stop bit, 2 synchronizer cycles, 1 register.
  localparam int LAT = CPB * 9 + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] o_data_out;
  logic       o_data_valid;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx         (rx),
    .o_data_out   (o_data_out),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         last_valid_cyc = 0;
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_data_valid || o_frame_err) begin
      checks++;
      if ((o_data_valid && o_frame_err) || prev_pulse) begin
        errors++;
        $display("FAIL pulse_exclusive: valid=%0b ferr=%0b prev=%0b expected single isolated pulse at cycle %0d",
                 o_data_valid, o_frame_err, prev_pulse, cyc);
      end
    end
    if (o_data_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got 0x%0h expected no data_valid at cycle %0d", o_data_out, cyc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (o_data_out !== sb_exp) begin
          errors++;
          $display("FAIL byte_data: got 0x%0h expected 0x%0h at cycle %0d", o_data_out, sb_exp, cyc);
        end
      end
    end
    if (o_frame_err) n_ferr++;
    prev_pulse = o_data_valid | o_frame_err;
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, t1, v1, nv0, nf0, busy_cnt;
    logic [7:0] d0;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h55};
    vecs[2] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E};
    vecs[3] = '{8'hC9, 1'b1, 1'b1, 1'b0, 8'hC9};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};

    // Reset state
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(3);
    check("reset_data_out", 32'(o_data_out), 32'h00);
    check("reset_valid", 32'(o_data_valid), 32'h0);
    check("reset_ferr", 32'(o_frame_err), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    reset = 1'b0;
    tick(4);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      nv0 = n_valid;
      nf0 = n_ferr;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, t0);
      rx = 1'b1;
      if (vecs[i].exp_valid) check("vec_latency", 32'(last_valid_cyc - t0), 32'(LAT));
      tick(2 * CPB);
      check("vec_valid_cnt", 32'(n_valid - nv0), 32'(vecs[i].exp_valid));
      check("vec_ferr_cnt", 32'(n_ferr - nf0), 32'(vecs[i].exp_ferr));
      check("vec_data_out", 32'(o_data_out), 32'(vecs[i].exp_out));
      check("vec_busy_idle", 32'(o_busy), 32'h0);
    end

    // Back-to-back frames, no idle bits
    nv0 = n_valid;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1, t1);
    v1 = last_valid_cyc;
    send_frame(8'h0F, 1'b1, t0);
    tick(2 * CPB);
    check("b2b_valid_cnt", 32'(n_valid - nv0), 32'd2);
    check("b2b_first_latency", 32'(v1 - t1), 32'(LAT));
    check("b2b_spacing", 32'(last_valid_cyc - v1), 32'(10 * CPB));
    check("b2b_data_out", 32'(o_data_out), 32'h0F);

    // Short glitch: 4 cycles low, less than half a bit
    nv0 = n_valid;
    nf0 = n_ferr;
    d0 = o_data_out;
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (o_busy) busy_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (o_busy) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
    check("glitch_busy_max", 32'(busy_cnt <= 10), 32'd1);
    check("glitch_busy_end", 32'(o_busy), 32'h0);
    check("glitch_no_valid", 32'(n_valid - nv0), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr - nf0), 32'd0);
    check("glitch_data_out", 32'(o_data_out), 32'(d0));

    // Reset in the middle of bit 4 of frame 0xFF
    nv0 = n_valid;
    nf0 = n_ferr;
    fork
      send_frame(8'hFF, 1'b1, t0);
      begin
        tick(5 * CPB + CPB / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_data_out", 32'(o_data_out), 32'h00);
        check("midreset_valid", 32'(o_data_valid), 32'h0);
        check("midreset_ferr", 32'(o_frame_err), 32'h0);
        check("midreset_busy", 32'(o_busy), 32'h0);
      end
    join
    tick(2 * CPB);
    check("midreset_no_valid", 32'(n_valid - nv0), 32'd0);
    check("midreset_no_ferr", 32'(n_ferr - nf0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, t0);
    tick(2 * CPB);
    check("after_reset_data_out", 32'(o_data_out), 32'h81);
    check("after_reset_valid_cnt", 32'(n_valid - nv0), 32'd1);

    // Break: line low for 3 frame-times
    nv0 = n_valid;
    nf0 = n_ferr;
    rx = 1'b0;
    tick(3 * 10 * CPB);
    check("break_busy_held", 32'(o_busy), 32'h1);
    rx = 1'b1;
    tick(2 * CPB);
    check("break_ferr_cnt", 32'(n_ferr - nf0), 32'd1);
    check("break_no_valid", 32'(n_valid - nv0), 32'd0);
    check("break_busy_end", 32'(o_busy), 32'h0);
    check("break_data_out", 32'(o_data_out), 32'h81);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, t0);
    tick(2 * CPB);
    check("after_break_data_out", 32'(o_data_out), 32'h3C);
    check("after_break_valid_cnt", 32'(n_valid - nv0), 32'd1);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial front end for the program-load path.
- Receives 8N1 asynchronous serial frames on a single line and presents each byte as a parallel value with a one-cycle strobe.
- Its outputs feed the parallel-to-RAM loader directly: data_out drives the loader's data input, data_valid drives its new-data strobe.
- Flags malformed frames so bad loads can be detected.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Legal range is 4 or more.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter. Derived; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idles high
- data_out  output  8  last correctly received byte
- data_valid  output  1  one-cycle pulse; data_out is new and stable
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset: applied on the clk edge where reset=1.
  - Outputs: data_out=0x00, data_valid=0, frame_err=0, busy=0.
  - Internal: state=IDLE, counters=0, shift register=0, synchronizer flops=1 (line idle).
  - Reset mid-frame abandons the frame with no pulse. After reset releases, reception restarts at the next falling edge.
- Input path:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - Timing counter held at 0.
  - When rx_s=0, go to START with the counter cleared.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer divide), then sample rx_s.
  - Sample 0: genuine start bit. Go to DATA with counter=0 and bit index=0.
  - Sample 1: glitch. Return to IDLE with no output activity.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first (bit index 0 = data bit 0).
  - After index 7 is sampled, go to STOP. Otherwise increment the index.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample 1: data_out takes the shifted byte and data_valid=1 for exactly the next cycle. Go to IDLE.
  - Sample 0: frame_err=1 for exactly the next cycle and data_out is unchanged. Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay here until rx_s=1, then go to IDLE.
  - A break condition (line held low) therefore produces exactly one frame_err and no spurious bytes.
- Latency: data_valid rises 1 cycle after the mid-stop-bit sample.
- Exclusivity: data_valid and frame_err are never high together and never high for 2 consecutive cycles.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit leaves half a bit of margin.
  - A start edge arriving immediately after the stop bit must be caught.
  - There is no dead time beyond the state transition.
- Output holding: data_out holds its value until the next valid frame. The downstream loader may sample it at any time after the data_valid pulse.
- Counter wrap: the timing counter resets to 0 on every sample point and never wraps past CLKS_PER_BIT-1.
- busy: registered, 1 in START/DATA/STOP/WAIT_HIGH.

Decomposition:
- Shared package/include holds:
  - localparams for state encodings (3-bit)
  - UART_DATA_BITS=8
  - default CLKS_PER_BIT, so the loader path and a future TX block share one baud constant.
- Sub-module sync_2ff: 1-bit, reset value parameterised (here 1). Reusable for other asynchronous inputs.

Test Plan (CLKS_PER_BIT=16 in simulation):
- Send frame 0x55 with ideal timing. Expect data_out=0x55 and one data_valid pulse, 1 cycle after mid-stop-bit (about 9.5 bit-times + 3 cycles after the start edge). frame_err stays 0.
- Send 0xA3, then 0x0F back-to-back with zero idle bits between them. Expect two data_valid pulses, with data_out=0xA3 then 0x0F, spaced by 10 bit-times (160 cycles).
- Send 0x00 with the stop bit driven low, then release the line high. Expect one frame_err pulse, no data_valid, and data_out keeps its previous value. Then send 0x7E, which must be received correctly.
- Pulse rx low for 4 cycles (less than half a bit), then hold it high. Expect the block to return to IDLE with no pulses, busy high for at most 8+2 cycles, and data_out unchanged.
- Assert reset for 1 cycle in the middle of bit 4 of frame 0xFF. Expect all outputs at their reset values and no pulse from the aborted frame. The next full frame 0x81 must yield data_out=0x81.
- Hold rx low for 3 frame-times (break), then release it. Expect exactly one frame_err, no data_valid, and normal reception of the next 0x3C.
